ps2_scan_rx: RTL and testbench
==============================

Name: ps2_scan_rx

Overview:
- Upstream stage of the keyboard scancode-to-ASCII translator.
- Deserialises PS/2 set-2 frames from the keyboard pins and strips the E0/F0/E1 prefixes.
- Tracks Shift state and presents clean {shift, e0, code} triples with press/release strobes to the translator and to the keyboard register logic.

Parameters:
- FILT_LEN, 4: consecutive clk samples ps2_clk must hold a new level before it is accepted (glitch filter).
- TO_CYCLES, 50000: idle clk cycles mid-frame before the frame is aborted; used only with PS2_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
- ps2_data  in  1  raw PS/2 data pin (asynchronous)
- code  out  8  scancode of the last key event, prefixes removed
- e0  out  1  last event carried an E0 prefix
- shift  out  1  current state: LShift or RShift held
- key_down  out  1  one-cycle strobe, make event; code/e0/shift are valid in the same cycle
- key_up  out  1  one-cycle strobe, break event; code/e0 are valid
- frame_err  out  1  one-cycle strobe on a parity, start, stop or timeout error

Behaviour:
- Reset: all outputs 0, FSM in IDLE, prefix flags, shift state and discard counter cleared.
- Input conditioning:
  - 2-FF synchroniser on both pins.
  - ps2_clk filtered: the filtered level changes only after FILT_LEN identical consecutive samples.
  - A falling edge of the filtered clock is the sample event; ps2_data is sampled in that same cycle.
- Frame FSM, one transition per sample event:
  - IDLE: data=0 → DATA with bit counter 0. data=1 → frame_err, stay in IDLE.
  - DATA: shift in LSB first. After 8 bits → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: frame is good when data=1 and the 9 bits (data + parity) have odd parity. Good frame → deliver byte. Otherwise frame_err and drop the byte. Either way → IDLE.
- Byte decode (one cycle after delivery):
  - Discard counter nonzero: decrement it, no output.
  - E1: load the discard counter with 7 (Pause sequence swallowed), clear flags.
  - E0: set e0 flag. F0: set release flag.
  - AA, FA, EE, FE, 00, FF: ignored, flags unchanged.
  - 12 or 59 without the E0 flag: shift state ← not release. No strobe. Clear flags.
  - 12 with the E0 flag (fake shift): discarded, clear flags.
  - Any other byte: drive code ← byte and e0 ← e0 flag, then pulse key_up if the release flag is set, else key_down. Clear both flags.
- Output hold:
  - code and e0 hold their values until the next strobe.
  - shift updates immediately when the shift state changes.
- Simultaneous events: key_down and key_up are never both asserted. frame_err never coincides with a strobe (strobes come one cycle after STOP).
- Error handling: any frame_err clears the E0 and release flags. The shift state and discard counter are unchanged.
- Latency: key_down/key_up assert 2 clk cycles after the sample event of the stop bit.
- Reset mid-frame: the partial frame is discarded with no strobe.

Optional Feature:
- Macro: PS2_TIMEOUT_EN.
- Defined:
  - An idle counter runs while the FSM is not in IDLE and clears on each sample event.
  - On reaching TO_CYCLES: frame_err pulses, FSM → IDLE, prefix flags cleared.
  - Provides recovery from hot-plug or lost clock edges.
- Undefined: no counter. A partial frame waits indefinitely for further edges.

Test Plan:
- Frame 1C (parity 0, stop 1) → one key_down, code=8'h1C, e0=0, shift=0. Then F0,1C → key_up, code=8'h1C.
- 12, 1C, F0 1C, F0 12 → shift=1 after the first 12; key_down code=1C with shift=1; key_up; shift=0 after F0 12. No strobe ever has code=12.
- E0 75 then E0 F0 75 → key_down code=8'h75 e0=1, then key_up code=8'h75 e0=1. A following plain 1C has e0=0.
- Frame 1C with parity bit 1 → frame_err one cycle, no strobe. Next good 1C → key_down normally.
- E1 14 77 E1 F0 14 F0 77 then 29 → no strobes for the first 8 bytes; key_down code=8'h29.
- 1-cycle low glitches on ps2_clk (shorter than FILT_LEN) → no bit captured. With PS2_TIMEOUT_EN: stop edges after 4 data bits, wait TO_CYCLES → frame_err, then a full 1C frame decodes correctly.

Source files
------------

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 set-2 receiver front end for the scancode translator.
// Synchronises and glitch-filters the keyboard pins, deserialises 11-bit
// frames and strips the E0/F0/E1 prefixes. It also tracks the Shift keys and
// strobes {shift, e0, code} make/break events.
// Optional feature: define PS2_TIMEOUT_EN to abort frames stalled mid-way
// for TO_CYCLES clk cycles.
module ps2_scan_rx #(
  parameter int FILT_LEN  = 4,
  parameter int TO_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       e0,
  output logic       shift,
  output logic       key_down,
  output logic       key_up,
  output logic       frame_err
);

  localparam int FW = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  // Input conditioning state
  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          samp_q;

  // Frame FSM state
  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shreg_q;
  logic          par_q;
  logic [7:0]    byte_q;
  logic          byte_vld_q;
  logic          frame_err_q;

  // Decoder state
  logic          e0_flag_q, rel_flag_q;
  logic [2:0]    disc_q;
  logic          lshift_q, rshift_q;
  logic [7:0]    code_q;
  logic          e0_q, key_down_q, key_up_q;

  // Synchronise both pins, filter ps2_clk and flag accepted falling edges.
  // The filtered level starts high because an idle PS/2 bus sits high.
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values and block ordering cannot matter.
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      samp_q     <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      samp_q   <= 1'b0;
      if (clk_s2_q != filt_q) begin
        if (filt_cnt_q == FW'(FILT_LEN - 1)) begin
          filt_q     <= clk_s2_q;
          filt_cnt_q <= '0;
          samp_q     <= filt_q;   // high only for a 1 -> 0 transition
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYCLES + 1);
  logic [TW-1:0] to_cnt_q;
`endif

  // Frame FSM: one transition per sample event, registered byte/error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_q       <= 1'b0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (samp_q) begin
        unique case (state_q)
          S_IDLE: begin
            if (!dat_s2_q) begin
              state_q   <= S_DATA;
              bit_cnt_q <= '0;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          S_DATA: begin
            shreg_q   <= {dat_s2_q, shreg_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            par_q   <= dat_s2_q;
            state_q <= S_STOP;
          end
          S_STOP: begin
            if (dat_s2_q && (^{shreg_q, par_q})) begin
              byte_q     <= shreg_q;
              byte_vld_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
`ifdef PS2_TIMEOUT_EN
      if (samp_q || state_q == S_IDLE) begin
        to_cnt_q <= '0;
      end else if (to_cnt_q == TW'(TO_CYCLES - 1)) begin
        to_cnt_q    <= '0;
        state_q     <= S_IDLE;
        frame_err_q <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
`endif
    end
  end

  // Classify the delivered byte.
  logic is_prefix, is_ignored, is_shift_key, is_consumed, emit;
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    is_prefix    = 1'b0;
    is_ignored   = 1'b0;
    is_shift_key = 1'b0;
    unique case (byte_q)
      8'hE0, 8'hF0, 8'hE1:                      is_prefix  = 1'b1;
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: is_ignored = 1'b1;
      8'h12, 8'h59:                             is_shift_key = !e0_flag_q;
      default: ;
    endcase
    is_consumed = byte_vld_q && (disc_q == 3'd0);
    // E0 12 is the fake shift and never becomes a key event.
    emit = is_consumed && !is_prefix && !is_ignored && !is_shift_key &&
           !(byte_q == 8'h12);
  end

  // Decoder: prefix flags, Pause swallowing, shift tracking and strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      e0_flag_q  <= 1'b0;
      rel_flag_q <= 1'b0;
      disc_q     <= '0;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      code_q     <= '0;
      e0_q       <= 1'b0;
      key_down_q <= 1'b0;
      key_up_q   <= 1'b0;
    end else begin
      key_down_q <= 1'b0;
      key_up_q   <= 1'b0;
      if (frame_err_q) begin
        e0_flag_q  <= 1'b0;
        rel_flag_q <= 1'b0;
      end else if (byte_vld_q) begin
        if (disc_q != 3'd0) begin
          disc_q <= disc_q - 3'd1;
        end else if (byte_q == 8'hE1) begin
          disc_q     <= 3'd7;
          e0_flag_q  <= 1'b0;
          rel_flag_q <= 1'b0;
        end else if (byte_q == 8'hE0) begin
          e0_flag_q <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          rel_flag_q <= 1'b1;
        end else if (!is_ignored) begin
          if (is_shift_key && byte_q == 8'h12) lshift_q <= !rel_flag_q;
          if (is_shift_key && byte_q == 8'h59) rshift_q <= !rel_flag_q;
          if (emit) begin
            code_q     <= byte_q;
            e0_q       <= e0_flag_q;
            key_down_q <= !rel_flag_q;
            key_up_q   <= rel_flag_q;
          end
          e0_flag_q  <= 1'b0;
          rel_flag_q <= 1'b0;
        end
      end
    end
  end

  assign code      = code_q;
  assign e0        = e0_q;
  assign shift     = lshift_q | rshift_q;
  assign key_down  = key_down_q;
  assign key_up    = key_up_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: directed bench for ps2_scan_rx. Drives PS/2 frames on the
// pins, counts strobes with a negedge monitor and compares against
// hand-computed expectations. Define PS2_TIMEOUT_EN to also exercise the
// frame timeout.
module tb_ps2_scan_rx;

  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_data;
  logic [7:0] code;
  logic       e0, shift, key_down, key_up, frame_err;

  ps2_scan_rx #(.FILT_LEN(4), .TO_CYCLES(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code     (code),
    .e0       (e0),
    .shift    (shift),
    .key_down (key_down),
    .key_up   (key_up),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Event monitor, sampled on the falling clk edge.
  int         dn_cnt = 0, up_cnt = 0, err_cnt = 0, both_cnt = 0, c12_cnt = 0;
  logic [7:0] last_code = '0;
  logic       last_e0 = 1'b0, last_shift = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (key_down) begin
        dn_cnt++;
        last_shift = shift;
      end
      if (key_up) up_cnt++;
      if (key_down || key_up) begin
        last_code = code;
        last_e0   = e0;
        if (code == 8'h12) c12_cnt++;
      end
      if (key_down && key_up) both_cnt++;
      if (frame_err) err_cnt++;
    end
  end

  int sn_dn = 0, sn_up = 0, sn_err = 0;
  int lat;

  task automatic expect_ev(input string tag, input int ddn, input int dup, input int derr);
    check({tag, "_down"}, dn_cnt - sn_dn, ddn);
    check({tag, "_up"},   up_cnt - sn_up, dup);
    check({tag, "_err"},  err_cnt - sn_err, derr);
    sn_dn  = dn_cnt;
    sn_up  = up_cnt;
    sn_err = err_cnt;
  endtask

  // Send the first nbits of a frame (11 = complete frame); bad_par flips parity.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] bits;
    logic        par;
    par  = (~^b) ^ bad_par;
    bits = {1'b1, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (10) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        lat = 0;
        for (int j = 1; j <= 20; j++) begin
          @(negedge clk);
          if (lat == 0 && (key_down || key_up)) lat = j;
        end
      end else begin
        repeat (20) @(negedge clk);
      end
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
  endtask

  task automatic glitch(input int len);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (len) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_code", code, 8'h00);
    check("rst_flags", {e0, shift, key_down, key_up, frame_err}, 5'b0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Plain make / break of 1C, with stop-bit-to-strobe latency.
    send(8'h1C);
    check("lat_1c", lat, 8);
    expect_ev("mk1c", 1, 0, 0);
    check("mk1c_code", last_code, 8'h1C);
    check("mk1c_e0sh", {last_e0, last_shift}, 2'b00);
    send(8'hF0); send(8'h1C);
    expect_ev("br1c", 0, 1, 0);
    check("br1c_code", last_code, 8'h1C);

    // Shift tracking.
    send(8'h12);
    check("sh_on", shift, 1'b1);
    expect_ev("sh12", 0, 0, 0);
    send(8'h1C);
    expect_ev("shk", 1, 0, 0);
    check("shk_shift", last_shift, 1'b1);
    send(8'hF0); send(8'h1C);
    expect_ev("shkup", 0, 1, 0);
    send(8'hF0); send(8'h12);
    check("sh_off", shift, 1'b0);
    expect_ev("sh12off", 0, 0, 0);
    send(8'h59);
    check("rsh_on", shift, 1'b1);
    send(8'hF0); send(8'h59);
    check("rsh_off", shift, 1'b0);
    expect_ev("rsh", 0, 0, 0);

    // Extended key.
    send(8'hE0); send(8'h75);
    expect_ev("e0mk", 1, 0, 0);
    check("e0mk_v", {last_e0, last_code}, {1'b1, 8'h75});
    send(8'hE0); send(8'hF0); send(8'h75);
    expect_ev("e0br", 0, 1, 0);
    check("e0br_v", {last_e0, last_code}, {1'b1, 8'h75});
    send(8'h1C);
    expect_ev("after_e0", 1, 0, 0);
    check("after_e0_v", {last_e0, last_code}, {1'b0, 8'h1C});

    // Fake shift (E0 12) and ignored bytes.
    send(8'hE0); send(8'h12);
    check("fake_sh", shift, 1'b0);
    send(8'hAA); send(8'hFA); send(8'h00);
    expect_ev("ignore", 0, 0, 0);

    // Parity error then recovery.
    send_frame(8'h1C, 1'b1, 11);
    expect_ev("par_err", 0, 0, 1);
    send(8'h1C);
    expect_ev("par_rec", 1, 0, 0);

    // Pause sequence swallowed.
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    expect_ev("pause", 0, 0, 0);
    send(8'h29);
    expect_ev("after_pause", 1, 0, 0);
    check("after_pause_c", last_code, 8'h29);

    // Clock glitches shorter than the filter length.
    glitch(1); glitch(3); glitch(1);
    expect_ev("glitch", 0, 0, 0);
    send(8'h1C);
    expect_ev("glitch_rec", 1, 0, 0);
    check("glitch_rec_c", last_code, 8'h1C);

    // Reset mid-frame discards the partial frame.
    send_frame(8'h66, 1'b0, 5);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    send(8'h1C);
    expect_ev("rst_mid", 1, 0, 0);
    check("rst_mid_c", last_code, 8'h1C);

`ifdef PS2_TIMEOUT_EN
    send_frame(8'h66, 1'b0, 5);
    repeat (TO + 20) @(negedge clk);
    expect_ev("timeout", 0, 0, 1);
    send(8'h1C);
    expect_ev("to_rec", 1, 0, 0);
    check("to_rec_c", last_code, 8'h1C);
`endif

    check("no_code12", c12_cnt, 0);
    check("no_both", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
